// File: rtl/cache_controller_pkg.sv
// Shared definitions for the cache controller, its directory and the cache array:
// address field layout, FSM state encoding and small helper functions.
package cache_controller_pkg;

  localparam int CC_ADDR_W = 10;
  localparam int CC_DATA_W = 32;
  localparam int CC_LINES  = 32;
  localparam int TAG_W     = 3;
  localparam int LINE_W    = 5;
  localparam int OFF_W     = 2;
  localparam int CNT_W     = 16;

  // Word address layout: {tag[9:7], line[6:2], offset[1:0]}
  localparam int OFF_LSB  = 0;
  localparam int LINE_LSB = OFF_LSB + OFF_W;
  localparam int TAG_LSB  = LINE_LSB + LINE_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    CACHE_RD = 3'd2,
    CAPTURE  = 3'd3,
    REFILL   = 3'd4,
    WR_MEM   = 3'd5,
    DONE     = 3'd6
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [CC_ADDR_W-1:0] a);
    return a[TAG_LSB +: TAG_W];
  endfunction

  function automatic logic [LINE_W-1:0] addr_line(input logic [CC_ADDR_W-1:0] a);
    return a[LINE_LSB +: LINE_W];
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Bundle of CPU, cache-array, main-memory and statistics signals around the
// cache controller. master = controller side, slave = environment side.
interface cache_controller_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // CPU side
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_busy;
  logic              cpu_done;
  // Cache array side
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wdata;
  logic              cache_write_en;
  logic              cache_read_en;
  logic [DATA_W-1:0] cache_rdata;
  // Main memory side
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  // Statistics
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_rdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_busy, cpu_done, cache_addr, cache_wdata, cache_write_en,
           cache_read_en, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_rdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_busy, cpu_done, cache_addr, cache_wdata, cache_write_en,
           cache_read_en, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_directory.sv
// Tag/valid directory: one valid bit and one tag per line, a combinational
// lookup port, a single write port and a synchronous clear of all valid bits.
module cache_directory
  import cache_controller_pkg::*;
#(
  parameter int LINES = CC_LINES
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic [LINE_W-1:0] lk_line_i,
  input  logic [TAG_W-1:0]  lk_tag_i,
  output logic              lk_hit_o,
  input  logic              wr_en_i,
  input  logic [LINE_W-1:0] wr_line_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic              wr_valid_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  // Valid bits: cleared together on clear, otherwise set/cleared by the write port.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_line_i] <= wr_valid_i;
    end
  end

  // Tags only matter while valid, so they need no clear; load when a line is validated.
  always_ff @(posedge clk) begin
    if (!clr_i && wr_en_i && wr_valid_i) begin
      tag_q[wr_line_i] <= wr_tag_i;
    end
  end

  assign lk_hit_o = valid_q[lk_line_i] && (tag_q[lk_line_i] == lk_tag_i);

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through / no-write-allocate cache controller.
// Read misses refill the whole 4-word line from main memory, then serve the
// requested word from the cache array. Read hits/misses are counted.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int ADDR_W = CC_ADDR_W,
  parameter int DATA_W = CC_DATA_W,
  parameter int LINES  = CC_LINES
) (
  input logic         clk,
  input logic         rst,
  cache_controller_if.master bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [OFF_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic                dir_hit;
  logic                dir_wr_en;
  logic                dir_wr_valid;
  logic [TAG_W-1:0]    req_tag;
  logic [LINE_W-1:0]   req_line;
  logic [ADDR_W-1:0]   refill_addr;

  assign req_tag     = addr_tag(addr_q);
  assign req_line    = addr_line(addr_q);
  assign refill_addr = {req_tag, req_line, k_q};

  cache_directory #(.LINES(LINES)) u_dir (
    .clk        (clk),
    .clr_i      (rst),
    .lk_line_i  (req_line),
    .lk_tag_i   (req_tag),
    .lk_hit_o   (dir_hit),
    .wr_en_i    (dir_wr_en),
    .wr_line_i  (req_line),
    .wr_tag_i   (req_tag),
    .wr_valid_i (dir_wr_valid)
  );

  // Next-state and strobe decode; every output defaults to 0 and is raised only in its state.
  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    we_d               = we_q;
    wdata_d            = wdata_q;
    rdata_d            = rdata_q;
    k_d                = k_q;
    hit_cnt_d          = hit_cnt_q;
    miss_cnt_d         = miss_cnt_q;
    dir_wr_en          = 1'b0;
    dir_wr_valid       = 1'b0;
    bus.cpu_done       = 1'b0;
    bus.cache_addr     = '0;
    bus.cache_wdata    = '0;
    bus.cache_write_en = 1'b0;
    bus.cache_read_en  = 1'b0;
    bus.mem_rd_req     = 1'b0;
    bus.mem_wr_req     = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          we_d    = bus.cpu_we;
          wdata_d = bus.cpu_wdata;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (we_q) begin
          state_d = WR_MEM;
        end else if (dir_hit) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
          state_d   = CACHE_RD;
        end else begin
          // Invalidate first so a refill cut short by reset leaves the line invalid.
          miss_cnt_d   = sat_inc(miss_cnt_q);
          dir_wr_en    = 1'b1;
          dir_wr_valid = 1'b0;
          k_d          = '0;
          state_d      = REFILL;
        end
      end
      CACHE_RD: begin
        bus.cache_read_en = 1'b1;
        bus.cache_addr    = addr_q;
        state_d           = CAPTURE;
      end
      CAPTURE: begin
        rdata_d = bus.cache_rdata;
        state_d = DONE;
      end
      REFILL: begin
        bus.mem_rd_req = 1'b1;
        bus.mem_addr   = refill_addr;
        if (bus.mem_ack) begin
          bus.cache_write_en = 1'b1;
          bus.cache_addr     = refill_addr;
          bus.cache_wdata    = bus.mem_rdata;
          k_d                = k_q + OFF_W'(1);
          if (k_q == {OFF_W{1'b1}}) begin
            dir_wr_en    = 1'b1;
            dir_wr_valid = 1'b1;
            state_d      = CACHE_RD;
          end else begin
            state_d = REFILL;
          end
        end else begin
          state_d = REFILL;
        end
      end
      WR_MEM: begin
        bus.mem_wr_req = 1'b1;
        bus.mem_addr   = addr_q;
        bus.mem_wdata  = wdata_q;
        if (bus.mem_ack) begin
          // Keep a resident copy coherent; misses are not allocated.
          if (dir_hit) begin
            bus.cache_write_en = 1'b1;
            bus.cache_addr     = addr_q;
            bus.cache_wdata    = wdata_q;
          end else begin
            bus.cache_write_en = 1'b0;
          end
          state_d = DONE;
        end else begin
          state_d = WR_MEM;
        end
      end
      DONE: begin
        bus.cpu_done = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      k_q        <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      k_q        <= k_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.cpu_busy  = (state_q != IDLE);
  assign bus.cpu_rdata = rdata_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: the stimulus side predicts each
// transaction from a word-level memory image and a line/tag table, a monitor
// compares every cpu_done against the predicted response.
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst;
  logic ack_always;

  always #5 clk = ~clk;

  cache_controller_if bus ();

  cache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [15:0] hc;
    logic [15:0] mc;
    int          nrd;
    int          nwr;
    int          ncw;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          errors  = 0;
  int          rd_ack_seen = 0;

  // Reference model
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_valid;
  logic [2:0]  ref_tag [32];
  logic [15:0] ref_hit;
  logic [15:0] ref_miss;
  logic [31:0] ref_last_rd;

  // Environment models
  logic [31:0] mem_arr [1024];
  logic [31:0] cache_arr [128];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Cache data array: synchronous write, registered read.
  always @(posedge clk) begin
    if (bus.cache_write_en) cache_arr[bus.cache_addr[6:0]] <= bus.cache_wdata;
    if (bus.cache_read_en) bus.cache_rdata <= cache_arr[bus.cache_addr[6:0]];
  end

  // Main memory responder.
  initial begin
    for (int n = 0; n < 1024; n++) mem_arr[n] = 32'hA000_0000 + n;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if ((bus.mem_rd_req || bus.mem_wr_req) && (ack_always || ($urandom_range(0, 1) == 1))) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_arr[bus.mem_addr];
        if (bus.mem_wr_req) mem_arr[bus.mem_addr] = bus.mem_wdata;
      end else begin
        bus.mem_ack   = (!ack_always && !bus.mem_rd_req && !bus.mem_wr_req && ($urandom_range(0, 7) == 0));
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Monitor: accumulate per-transaction traffic, compare at cpu_done.
  int m_rd = 0, m_wr = 0, m_cw = 0, m_busy = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      m_rd = 0; m_wr = 0; m_cw = 0; m_busy = 0;
    end else begin
      if (bus.cpu_busy) m_busy++;
      if (bus.mem_rd_req && bus.mem_ack) begin m_rd++; rd_ack_seen++; end
      if (bus.mem_wr_req && bus.mem_ack) m_wr++;
      if (bus.cache_write_en) m_cw++;
      if (bus.cache_write_en || bus.cache_read_en)
        check("cache_strobe_excl", {31'd0, bus.cache_write_en & bus.cache_read_en}, 32'd0);
      if (bus.cpu_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("cpu_rdata", bus.cpu_rdata, e.rdata);
          check("hit_cnt", {16'd0, bus.hit_cnt}, {16'd0, e.hc});
          check("miss_cnt", {16'd0, bus.miss_cnt}, {16'd0, e.mc});
          check("mem_rd_words", m_rd, e.nrd);
          check("mem_wr_words", m_wr, e.nwr);
          check("cache_writes", m_cw, e.ncw);
          if (e.lat != 0) check("hit_latency", m_busy, e.lat);
        end
        m_rd = 0; m_wr = 0; m_cw = 0; m_busy = 0;
      end
    end
  end

  // Predict the transaction, queue the expectation, then present it to the DUT.
  task automatic send(input logic we, input logic [9:0] addr, input logic [31:0] wd, input logic spur);
    exp_t       e;
    logic [4:0] ln;
    logic [2:0] tg;
    logic       hit;
    int         cyc;
    ln  = addr[6:2];
    tg  = addr[9:7];
    hit = ref_valid[ln] && (ref_tag[ln] == tg);
    e.nrd = 0; e.nwr = 0; e.ncw = 0; e.lat = 0;
    if (!we) begin
      if (hit) begin
        if (ref_hit != 16'hFFFF) ref_hit++;
        e.lat = 4;
      end else begin
        if (ref_miss != 16'hFFFF) ref_miss++;
        ref_valid[ln] = 1'b1;
        ref_tag[ln]   = tg;
        e.nrd = 4;
        e.ncw = 4;
      end
      ref_last_rd = ref_mem[addr];
    end else begin
      ref_mem[addr] = wd;
      e.nwr = 1;
      e.ncw = hit ? 1 : 0;
    end
    e.rdata = ref_last_rd;
    e.hc    = ref_hit;
    e.mc    = ref_miss;
    exp_q.push_back(e);
    cyc = 0;
    while (bus.cpu_busy && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (bus.cpu_busy) check("idle_timeout", 32'd1, 32'd0);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    @(posedge clk); #1;
    if (spur) begin
      bus.cpu_we = ~we; bus.cpu_addr = addr ^ 10'h3FF; bus.cpu_wdata = ~wd;
      repeat (2) begin @(posedge clk); #1; end
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin @(posedge clk); #1; cyc++; end
    if (exp_q.size() != 0) begin
      check("done_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic we, input logic [9:0] addr, input logic [31:0] wd, input logic spur);
    send(we, addr, wd, spur);
    wait_done();
  endtask

  task automatic check_reset_outputs();
    check("rst_flags", {26'd0, bus.cpu_busy, bus.cpu_done, bus.cache_write_en, bus.cache_read_en,
                        bus.mem_rd_req, bus.mem_wr_req}, 32'd0);
    check("rst_addrs", {12'd0, bus.cache_addr, bus.mem_addr}, 32'd0);
    check("rst_wdata", bus.cache_wdata | bus.mem_wdata, 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'd0);
    check("rst_counters", {bus.hit_cnt, bus.miss_cnt}, 32'd0);
  endtask

  task automatic ref_reset();
    ref_valid   = 32'd0;
    ref_hit     = 16'd0;
    ref_miss    = 16'd0;
    ref_last_rd = 32'd0;
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          base;
    int          cyc;
    logic [9:0]  a;
    for (int n = 0; n < 1024; n++) ref_mem[n] = 32'hA000_0000 + n;
    for (int n = 0; n < 32; n++) ref_tag[n] = 3'd0;
    ref_reset();
    ack_always    = 1'b1;
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 10'd0;
    bus.cpu_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;

    // Cold miss, then hits on the refilled line (second one with spurious requests while busy).
    run(1'b0, 10'h085, 32'd0, 1'b0);
    run(1'b0, 10'h086, 32'd0, 1'b1);
    run(1'b0, 10'h087, 32'd0, 1'b0);
    // Same line, different tag: evicts, then the original tag misses again.
    run(1'b0, 10'h185, 32'd0, 1'b0);
    run(1'b0, 10'h085, 32'd0, 1'b0);
    // Write hit updates memory and cache; write miss updates memory only.
    run(1'b1, 10'h084, 32'hDEAD_BEEF, 1'b0);
    run(1'b0, 10'h084, 32'd0, 1'b0);
    run(1'b1, 10'h300, 32'h1234_5678, 1'b0);
    run(1'b0, 10'h300, 32'd0, 1'b0);

    // Reset in the middle of a refill, after its second word.
    send(1'b0, 10'h185, 32'd0, 1'b0);
    base = rd_ack_seen;
    cyc  = 0;
    while ((rd_ack_seen - base) < 2 && cyc < 50) begin @(negedge clk); #1; cyc++; end
    if ((rd_ack_seen - base) < 2) check("refill_ack_timeout", rd_ack_seen - base, 32'd2);
    rst = 1'b1;
    exp_q.delete();
    ref_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    run(1'b0, 10'h085, 32'd0, 1'b0);
    run(1'b0, 10'h184, 32'd0, 1'b0);
    run(1'b0, 10'h185, 32'd0, 1'b0);

    // Saturation of the hit counter.
    force dut.hit_cnt_q = 16'hFFFF;
    @(posedge clk); @(posedge clk); #1;
    release dut.hit_cnt_q;
    ref_hit = 16'hFFFF;
    run(1'b0, 10'h186, 32'd0, 1'b0);

    // Randomized traffic over a few lines and tags with random memory latency.
    ack_always = 1'b0;
    for (int i = 0; i < 150; i++) begin
      a = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      run(($urandom_range(0, 9) < 3), a, $urandom, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameters SHALL be: ADDR_W, 10, byte-less word address {tag[9:7], line[6:2], offset[1:0]}; DATA_W, 32, word width; LINES, 32, directory depth.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cpu_req  in  1  request strobe, sampled only in IDLE.
REQ-005 cpu_we  in  1  1 = write, 0 = read.
REQ-006 cpu_addr  in  10  request word address.
REQ-007 cpu_wdata  in  32  write data.
REQ-008 cpu_rdata  out  32  read data; held until the next read completes.
REQ-009 cpu_busy  out  1  high in every state except IDLE.
REQ-010 cpu_done  out  1  one-cycle completion pulse.
REQ-011 cache_addr, cache_wdata  out  10, 32  address and data to the cache array.
REQ-012 cache_write_en, cache_read_en  out  1, 1  cache array strobes, mutually exclusive.
REQ-013 cache_rdata  in  32  registered cache output, valid one cycle after cache_read_en.
REQ-014 mem_rd_req, mem_wr_req  out  1, 1  main-memory strobes, held until mem_ack.
REQ-015 mem_addr, mem_wdata  out  10, 32  memory word address and write data.
REQ-016 mem_rdata, mem_ack  in  32, 1  memory read data, valid in the mem_ack cycle; mem_ack completes one word.
REQ-017 hit_cnt, miss_cnt  out  16, 16  saturating read hit/miss counters.

Function
REQ-018 The controller SHALL own a directory of 32 valid bits and 32 3-bit tags indexed by line; hit = valid[line] AND tag_dir[line] == tag.
REQ-019 FSM states SHALL be IDLE, LOOKUP, CACHE_RD, CAPTURE, REFILL, WR_MEM, DONE.
REQ-020 IDLE: cpu_req=1 latches cpu_addr/cpu_we/cpu_wdata and moves to LOOKUP; cpu_req while busy SHALL be ignored.
REQ-021 LOOKUP: read hit -> CACHE_RD, hit_cnt+1; read miss -> REFILL, miss_cnt+1, valid[line] cleared, word counter k=0; write -> WR_MEM.
REQ-022 CACHE_RD: cache_read_en=1, cache_addr=latched address, one cycle -> CAPTURE.
REQ-023 CAPTURE: cpu_rdata <= cache_rdata at cycle end -> DONE; read-hit cpu_done SHALL occur 4 cycles after the accept edge.
REQ-024 REFILL: mem_rd_req=1, mem_addr={tag,line,k}; on mem_ack, same cycle: cache_write_en=1, cache_addr={tag,line,k}, cache_wdata=mem_rdata, k+1.
REQ-025 k SHALL be 2 bits; ack at k=3 sets valid[line]=1, tag_dir[line]=tag, k wraps to 0, -> CACHE_RD (requested word read from cache).
REQ-026 A refill SHALL write all 4 offsets regardless of requested offset; mem_ack in the same cycle as first mem_rd_req assertion is legal.
REQ-027 WR_MEM: write-through, no-write-allocate; mem_wr_req=1 with latched address/data until mem_ack; in the ack cycle, if hit, cache_write_en=1 with cpu_wdata; -> DONE; directory unchanged.
REQ-028 DONE: cpu_done=1 one cycle -> IDLE.
REQ-029 mem_ack outside REFILL/WR_MEM SHALL be ignored.
REQ-030 Counters SHALL saturate at 16'hFFFF; writes SHALL not count.
REQ-031 All strobes not named for a state SHALL be 0 in that state.

Reset
REQ-032 rst=1 at any edge, including mid-refill, SHALL force IDLE, all valid bits 0, k=0, counters 0, cpu_rdata 0; all outputs 0 in the cycle after reset.
REQ-033 A refill interrupted by reset SHALL leave its line invalid.

Structure
REQ-034 FSM state encoding and address field widths/positions (TAG 3, LINE 5, OFFSET 2) SHALL live in a shared package used with the cache array.
REQ-035 The tag/valid directory SHALL be a sub-module cache_directory (lookup port, write port, synchronous clear).

Verification
REQ-036 Cold read 0x085, memory word n = 0xA000_0000+n, ack every cycle -> 4 cache writes to 0x084..0x087, cpu_rdata=0xA000_0085, miss_cnt=1.
REQ-037 Repeat read 0x086 -> no memory traffic, cpu_done 4 cycles after accept, cpu_rdata=0xA000_0086, hit_cnt=1.
REQ-038 Read 0x185 (same line, tag 3) -> refill evicts; subsequent read 0x085 misses, miss_cnt=3.
REQ-039 Write 0x084 data 0xDEAD_BEEF on hit -> one mem write plus one cache write; write 0x300 miss -> mem write only, directory unchanged.
REQ-040 rst after second refill ack -> IDLE, read 0x085 misses again; cpu_req during busy -> ignored; hit_cnt forced to 0xFFFF stays 0xFFFF after a hit.
